bit_serial_add_ctrl: RTL and testbench
======================================

// Module: bit_serial_add_ctrl
// PURPOSE
//  Sequencer that time-multiplexes a single 1-bit full-adder cell to add two WIDTH-bit operands, LSB first.
//  It takes one bit per clock, holds the carry in a flip-flop, and shifts sum bits into a result register.
//  Sits between a requester (start/ready/done handshake) and the gate-level full-adder datapath.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only when ready=1
//  a          in   WIDTH  operand A; captured on the accepting edge
//  b          in   WIDTH  operand B; captured on the accepting edge
//  carryin    in   1      initial carry; captured on the accepting edge
//  ready      out  1      1 in IDLE only
//  busy       out  1      1 in RUN
//  done       out  1      one-cycle pulse; result/flags valid
//  sum        out  WIDTH  result; held from done until the next accept
//  carryout   out  1      final carry out of bit WIDTH-1; held like sum
//  overflow   out  1      signed overflow (carry into MSB XOR carry out of MSB); held like sum
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; sum=0, carryout=0, overflow=0, done=0, busy=0; ready=1 after release.
//  - FSM states: IDLE, RUN, DONE.
//      IDLE --start--> RUN; RUN --(bit count == WIDTH-1)--> DONE; DONE --> IDLE (unconditional).
//  - Accept edge E0 (IDLE & start): opA<=a, opB<=b, carry reg<=carryin, cnt<=0, sum<=0.
//  - RUN, each edge: FA inputs = opA[0], opB[0], carry reg.
//    sum<={fa_sum, sum[WIDTH-1:1]}; opA/opB shift right; carry reg<=fa_cout; cnt++.
//    On the edge with cnt==WIDTH-1: latch carryout<=fa_cout and overflow<=carry reg ^ fa_cout.
//  - Latency: done=1 in the cycle after edge E(WIDTH), exactly one cycle; ready returns at E(WIDTH+1).
//  - start while busy/DONE is ignored (no queueing). a/b/carryin changes after E0 have no effect.
//  - cnt width is $clog2(WIDTH); counter never wraps inside a single operation.
//  - sum bits are not valid until done, and the bench checks them only then.
//  - Reset asserted mid-RUN aborts the operation; no done pulse is produced for it.
//  - FA cell has gate delays (2 levels x 50 units); clk period >= 200 time units.
// CONFIGURATION
//  BSA_SUBTRACT_EN defined: extra input port `sub` (1 bit), captured at E0.
//    When sub=1, opB<=~b and carry reg<=1 (carryin ignored), giving sum=a-b.
//    In this mode carryout=1 means no borrow; overflow is signed-subtract overflow.
//  BSA_SUBTRACT_EN undefined: no `sub` port; add only.
// STRUCTURE
//  - Shared include bsa_defs.vh holds:
//      state encodings BSA_IDLE=2'd0, BSA_RUN=2'd1, BSA_DONE=2'd2;
//      the default WIDTH constant.
//  - Datapath is exactly one instance of the structural full-adder cell; no behavioural '+' anywhere.
//  - One sub-module is natural: bsa_shift_unit, covering the operand/result shift registers plus the carry flop.
//    The FSM and counter stay in the top module.
// TESTING  (WIDTH=8)
//  1. a=8'h5A, b=8'h33, cin=0, start
//     -> done exactly 8 edges after accept; sum=8'h8D, carryout=0, overflow=1.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carryout=1, overflow=0.
//  3. a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, carryout=0, overflow=1.
//  4. Accept a=8'h0F, b=8'h01; pulse start again with new operands at RUN cycle 3
//     -> second start ignored; sum=8'h10; ready=1 one cycle after done.
//  5. Accept, then drop rst_n at RUN cycle 4 -> all outputs 0 immediately; no done.
//     After release, a=8'h01, b=8'h01 -> sum=8'h02.
//  6. BSA_SUBTRACT_EN: a=8'h0A, b=8'h03, sub=1 -> sum=8'h07, carryout=1, overflow=0.
//     a=8'h03, b=8'h0A, sub=1 -> sum=8'hF9, carryout=0.

Source files
------------

// File: rtl/bit_serial_add_ctrl_pkg.sv
// Shared constants, FSM encoding and flag helper for the bit-serial adder sequencer.
// Optional feature macro: BSA_SUBTRACT_EN (adds a subtract-mode request bit).
package bit_serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        BSA_IDLE = 2'd0,
        BSA_RUN  = 2'd1,
        BSA_DONE = 2'd2
    } bsa_state_e;

    // Two's-complement overflow: carry into the MSB disagrees with carry out of it.
    function automatic logic signed_ovf(input logic carry_into_msb, input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

endpackage

// File: rtl/bit_serial_add_ctrl_if.sv
// Requester-side handshake and result bundle for bit_serial_add_ctrl.
// Optional feature macro: BSA_SUBTRACT_EN (adds the sub request bit).
interface bit_serial_add_ctrl_if #(parameter int WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
`ifdef BSA_SUBTRACT_EN
    logic             sub;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

`ifdef BSA_SUBTRACT_EN
    modport master (output start, a, b, carryin, sub,
                    input  ready, busy, done, sum, carryout, overflow);
    modport slave  (input  start, a, b, carryin, sub,
                    output ready, busy, done, sum, carryout, overflow);
`else
    modport master (output start, a, b, carryin,
                    input  ready, busy, done, sum, carryout, overflow);
    modport slave  (input  start, a, b, carryin,
                    output ready, busy, done, sum, carryout, overflow);
`endif

endinterface

// File: rtl/bit_serial_add_ctrl_shift_unit.sv
// Operand/result shift registers with the carry flop, plus the gate-level full-adder cell
// that the sequencer time-multiplexes one bit per clock.
module bsa_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p_s;
    logic g_s;
    logic t_s;

    xor x_prop (p_s, a, b);
    xor x_sum  (s, p_s, cin);
    and a_gen  (g_s, a, b);
    and a_prop (t_s, p_s, cin);
    or  o_cout (cout, g_s, t_s);

endmodule

module bsa_shift_unit #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             op_a0,
    output logic             op_b0,
    output logic             carry,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;

    // Capture operands on accept, then consume LSB first while sum bits enter at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r  <= '0;
            op_b_r  <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
        end else if (load) begin
            op_a_r  <= a;
            op_b_r  <= b;
            sum_r   <= '0;
            carry_r <= cin;
        end else if (shift) begin
            op_a_r  <= {1'b0, op_a_r[WIDTH-1:1]};
            op_b_r  <= {1'b0, op_b_r[WIDTH-1:1]};
            sum_r   <= {fa_sum, sum_r[WIDTH-1:1]};
            carry_r <= fa_cout;
        end else begin
            op_a_r  <= op_a_r;
            op_b_r  <= op_b_r;
            sum_r   <= sum_r;
            carry_r <= carry_r;
        end
    end

    assign op_a0 = op_a_r[0];
    assign op_b0 = op_b_r[0];
    assign carry = carry_r;
    assign sum   = sum_r;

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial add sequencer: one full-adder cell, WIDTH clocks per operation, start/ready/done handshake.
// Optional feature macro: BSA_SUBTRACT_EN (sub=1 computes a-b by inverting b and forcing carry-in).
module bit_serial_add_ctrl
    import bit_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bit_serial_add_ctrl_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    bsa_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             carryout_r;
    logic             overflow_r;

    logic             load_s;
    logic             shift_s;
    logic [WIDTH-1:0] b_load_s;
    logic             cin_load_s;
    logic             op_a0_s;
    logic             op_b0_s;
    logic             carry_s;
    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] sum_s;

    // Datapath control derived from the current state.
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        if (state_r == BSA_IDLE) begin
            load_s = bus.start;
        end else begin
            shift_s = (state_r == BSA_RUN);
        end
    end

`ifdef BSA_SUBTRACT_EN
    // Subtract as a + ~b + 1; the caller's carryin is irrelevant in this mode.
    always_comb begin
        b_load_s   = bus.b;
        cin_load_s = bus.carryin;
        if (bus.sub) begin
            b_load_s   = ~bus.b;
            cin_load_s = 1'b1;
        end else begin
            b_load_s   = bus.b;
            cin_load_s = bus.carryin;
        end
    end
`else
    // Add-only build: operands pass straight through.
    always_comb begin
        b_load_s   = bus.b;
        cin_load_s = bus.carryin;
    end
`endif

    bsa_full_adder u_fa (
        .a    (op_a0_s),
        .b    (op_b0_s),
        .cin  (carry_s),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    bsa_shift_unit #(.WIDTH(WIDTH)) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .shift   (shift_s),
        .a       (bus.a),
        .b       (b_load_s),
        .cin     (cin_load_s),
        .fa_sum  (fa_sum_s),
        .fa_cout (fa_cout_s),
        .op_a0   (op_a0_s),
        .op_b0   (op_b0_s),
        .carry   (carry_s),
        .sum     (sum_s)
    );

    // Sequencer FSM, bit counter and registered handshake/flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= BSA_IDLE;
            cnt_r      <= '0;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            carryout_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                BSA_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= BSA_RUN;
                        cnt_r   <= '0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= BSA_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                BSA_RUN: begin
                    // The counter holds on the final bit so it never wraps mid-operation.
                    if (cnt_r == LAST_BIT) begin
                        state_r    <= BSA_DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        carryout_r <= fa_cout_s;
                        overflow_r <= signed_ovf(carry_s, fa_cout_s);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                BSA_DONE: begin
                    state_r <= BSA_IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= BSA_IDLE;
                    cnt_r   <= '0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready    = ready_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_s;
    assign bus.carryout = carryout_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Scoreboard bench for bit_serial_add_ctrl (WIDTH=8): directed vectors, decoupled done monitor.
// Optional feature macro: BSA_SUBTRACT_EN (enables the subtract vectors).
module tb_bit_serial_add_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    exp_t sb[$];

    bit_serial_add_ctrl_if #(.WIDTH(W)) bus ();

    bit_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation and compares result, flags and latency.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending operation at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum", 32'(bus.sum), 32'(e.sum));
                    check("carryout", 32'(bus.carryout), 32'(e.cout));
                    check("overflow", 32'(bus.overflow), 32'(e.ovf));
                    check("done_latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                         input logic expect_done, input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        check("ready_before_accept", 32'(bus.ready), 32'd1);
        bus.a       = a;
        bus.b       = b;
        bus.carryin = cin;
`ifdef BSA_SUBTRACT_EN
        bus.sub     = sub;
`else
        if (sub) $display("note: sub ignored in add-only build");
`endif
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (expect_done) begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            e.cyc  = cyc + W;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done_then_ready();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * W && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", 4 * W);
        end else begin
            check("ready_low_in_done", 32'(bus.ready), 32'd0);
            @(posedge clk);
            #1;
            check("ready_after_done", 32'(bus.ready), 32'd1);
            check("done_one_cycle", 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.carryin = 1'b0;
`ifdef BSA_SUBTRACT_EN
        bus.sub     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #10;
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_flags", {30'd0, bus.carryout, bus.overflow}, 32'd0);

        issue(8'h5A, 8'h33, 1'b0, 1'b0, 1'b1, 8'h8D, 1'b0, 1'b1);
        check("busy_in_run", 32'(bus.busy), 32'd1);
        check("ready_low_in_run", 32'(bus.ready), 32'd0);
        wait_done_then_ready();

        issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        wait_done_then_ready();

        issue(8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
        wait_done_then_ready();

        // Second start mid-RUN with different operands must be ignored.
        issue(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.a       = 8'hFF;
        bus.b       = 8'hFF;
        bus.carryin = 1'b1;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done_then_ready();
        repeat (2) @(posedge clk);
        #1;
        check("ignored_start_no_busy", 32'(bus.busy), 32'd0);

        // Reset during RUN aborts with no done pulse.
        issue(8'h55, 8'h2A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #20;
        rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_flags", {29'd0, bus.carryout, bus.overflow, bus.done}, 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        check("abort_no_busy", 32'(bus.busy), 32'd0);
        issue(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
        wait_done_then_ready();

`ifdef BSA_SUBTRACT_EN
        issue(8'h0A, 8'h03, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0);
        wait_done_then_ready();
        issue(8'h03, 8'h0A, 1'b1, 1'b1, 1'b1, 8'hF9, 1'b0, 1'b0);
        wait_done_then_ready();
`endif

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
